// File: rtl/dino_pkg.sv
// dino_pkg: shared constants and types for the dinosaur-runner motion block.
//   - default parameter values for dino_motion_ctrl
//   - jump_state_e: GROUND / RISE / FALL
//   - SPEED_MAX: ground scroll speed ceiling
package dino_pkg;
  localparam int DEF_DEB_BITS    = 4;
  localparam int DEF_TICK_CYCLES = 1_000_000;
  localparam int DEF_JUMP_PEAK   = 40;
  localparam int DEF_SPEED_TICKS = 256;

  localparam int NUM_SW  = 16;
  localparam int NUM_DEB = NUM_SW + 1;  // switches plus the jump button

  localparam logic [3:0] SPEED_MAX = 4'd15;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_e;
endpackage

// File: rtl/dino_motion_ctrl_if.sv
// dino_motion_ctrl_if: board-side signals of the motion controller.
//   master: drives raw BTN_JUMP / SW, observes conditioned outputs
//   slave : the controller; consumes raw inputs, drives SW_OK,
//           dinosaur_height, game_status, speed, ground_position
interface dino_motion_ctrl_if;
  import dino_pkg::*;

  logic              BTN_JUMP;
  logic [NUM_SW-1:0] SW;
  logic [NUM_SW-1:0] SW_OK;
  logic [5:0]        dinosaur_height;
  logic              game_status;
  logic [3:0]        speed;
  logic [5:0]        ground_position;

  modport master (
    output BTN_JUMP, SW,
    input  SW_OK, dinosaur_height, game_status, speed, ground_position
  );

  modport slave (
    input  BTN_JUMP, SW,
    output SW_OK, dinosaur_height, game_status, speed, ground_position
  );
endinterface

// File: rtl/dino_motion_ctrl_anti_jitter.sv
// anti_jitter: single-bit debouncer.
//   clk, rst_n : clock, async active-low reset
//   in_i       : raw input
//   out_o      : debounced output; follows in_i only after in_i has
//                differed from it for 2^DEB_BITS consecutive edges
module anti_jitter
  import dino_pkg::*;
#(
  parameter int DEB_BITS = DEF_DEB_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic out_o
);

  logic                out_q;
  logic [DEB_BITS-1:0] cnt_q;

  // Any cycle where the input agrees with the output restarts the count,
  // so a glitch shorter than the window never reaches out_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else if (in_i == out_q) begin
      cnt_q <= '0;
    end else if (cnt_q == '1) begin
      out_q <= in_i;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DEB_BITS'(1);
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// dino_motion_ctrl: input conditioning and motion state for the runner game.
//   CLK, clrn : clock, async active-low reset
//   bus       : slave side of dino_motion_ctrl_if
//     BTN_JUMP, SW          raw button / switches
//     SW_OK                 debounced switches
//     dinosaur_height       jump height above ground (0 = on ground)
//     game_status           0 idle, 1 running (sticky until reset)
//     speed                 ground scroll speed 1..15
//     ground_position       ground scroll offset mod 64
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter int DEB_BITS    = DEF_DEB_BITS,
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int JUMP_PEAK   = DEF_JUMP_PEAK,
  parameter int SPEED_TICKS = DEF_SPEED_TICKS
) (
  input  logic              CLK,
  input  logic              clrn,
  dino_motion_ctrl_if.slave bus
);

  localparam int TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SCW = (SPEED_TICKS > 1) ? $clog2(SPEED_TICKS) : 1;

  // ---------------- debounce: 16 switches + jump button ----------------
  logic [NUM_DEB-1:0] raw, deb;
  assign raw = {bus.BTN_JUMP, bus.SW};

  for (genvar i = 0; i < NUM_DEB; i++) begin : g_deb
    anti_jitter #(.DEB_BITS(DEB_BITS)) u_aj (
      .clk   (CLK),
      .rst_n (clrn),
      .in_i  (raw[i]),
      .out_o (deb[i])
    );
  end

  assign bus.SW_OK = deb[NUM_SW-1:0];

  // ---------------- motion tick ----------------
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  // tick is high in the last count cycle, so state advances on the same
  // edge that wraps the counter back to 0.
  assign tick = (tick_cnt_q == TW'(TICK_CYCLES - 1));

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
  end

  // ---------------- press detect / game status ----------------
  logic btn_prev_q, press, status_q;

  assign press = deb[NUM_DEB-1] & ~btn_prev_q;

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      btn_prev_q <= 1'b0;
      status_q   <= 1'b0;
    end else begin
      btn_prev_q <= deb[NUM_DEB-1];
      status_q   <= status_q | press;
    end
  end

  // ---------------- jump FSM ----------------
  jump_state_e state_q;
  logic [5:0]  height_q;

  // Any press on the ground jumps: either the game is already running or
  // this same press is starting it. Presses mid-air are ignored.
  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      state_q  <= GROUND;
      height_q <= '0;
    end else begin
      case (state_q)
        GROUND: if (press) state_q <= RISE;
        RISE: if (tick) begin
          height_q <= height_q + 6'd1;
          if (height_q >= 6'(JUMP_PEAK - 1)) state_q <= FALL;
        end
        FALL: if (tick) begin
          height_q <= height_q - 6'd1;
          if (height_q <= 6'd1) state_q <= GROUND;
        end
        default: state_q <= GROUND;
      endcase
    end
  end

  // ---------------- ground scroll ----------------
  logic [5:0]     pos_q, pos_d;
  logic [3:0]     spd_q, spd_d;
  logic [SCW-1:0] scnt_q, scnt_d;

  // Position always advances by the pre-increment speed.
  always_comb begin
    pos_d  = pos_q;
    spd_d  = spd_q;
    scnt_d = scnt_q;
    if (status_q && tick) begin
      pos_d = pos_q + {2'b00, spd_q};
      if (scnt_q == SCW'(SPEED_TICKS - 1)) begin
        scnt_d = '0;
        if (spd_q != SPEED_MAX) spd_d = spd_q + 4'd1;
      end else begin
        scnt_d = scnt_q + SCW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      pos_q  <= '0;
      spd_q  <= 4'd1;
      scnt_q <= '0;
    end else begin
      pos_q  <= pos_d;
      spd_q  <= spd_d;
      scnt_q <= scnt_d;
    end
  end

  assign bus.dinosaur_height = height_q;
  assign bus.game_status     = status_q;
  assign bus.speed           = spd_q;
  assign bus.ground_position = pos_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// tb_dino_motion_ctrl: two controllers share clock, reset and raw inputs.
//   dut_a: fast ticks (4 cycles), slow speed ramp -> jump shape, wrap at 64
//   dut_b: slow ticks (32 cycles), ramp every 2 ticks -> speed ramp,
//          saturation, mid-air press rejection
module tb_dino_motion_ctrl;
  import dino_pkg::*;

  localparam int DEB = 4;
  localparam int TA  = 4;
  localparam int TB  = 32;
  localparam int PK  = 5;
  localparam int STA = 256;
  localparam int STB = 2;

  logic        CLK = 1'b0;
  logic        clrn = 1'b0;
  logic        btn = 1'b0;
  logic [15:0] sw = '0;

  initial forever #5 CLK = ~CLK;

  dino_motion_ctrl_if ifa ();
  dino_motion_ctrl_if ifb ();
  assign ifa.BTN_JUMP = btn;
  assign ifa.SW       = sw;
  assign ifb.BTN_JUMP = btn;
  assign ifb.SW       = sw;

  dino_motion_ctrl #(.DEB_BITS(DEB), .TICK_CYCLES(TA), .JUMP_PEAK(PK), .SPEED_TICKS(STA))
    dut_a (.CLK(CLK), .clrn(clrn), .bus(ifa));
  dino_motion_ctrl #(.DEB_BITS(DEB), .TICK_CYCLES(TB), .JUMP_PEAK(PK), .SPEED_TICKS(STB))
    dut_b (.CLK(CLK), .clrn(clrn), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_a_height"}, ifa.dinosaur_height, 0);
    chk({tag, "_a_status"}, ifa.game_status, 0);
    chk({tag, "_a_speed"},  ifa.speed, 1);
    chk({tag, "_a_pos"},    ifa.ground_position, 0);
    chk({tag, "_a_sw_ok"},  ifa.SW_OK, 0);
    chk({tag, "_b_height"}, ifb.dinosaur_height, 0);
    chk({tag, "_b_status"}, ifb.game_status, 0);
    chk({tag, "_b_speed"},  ifb.speed, 1);
    chk({tag, "_b_pos"},    ifb.ground_position, 0);
    chk({tag, "_b_sw_ok"},  ifb.SW_OK, 0);
  endtask

  // ---------------- height scoreboard ----------------
  typedef struct {
    int h;
    bit first;
  } hexp_t;

  hexp_t hq_a[$];
  hexp_t hq_b[$];

  task automatic push_jump(input bit to_a, input bit to_b);
    for (int s = 1; s <= 2 * PK; s++) begin
      hexp_t e;
      e.h     = (s <= PK) ? s : 2 * PK - s;
      e.first = (s == 1);
      if (to_a) hq_a.push_back(e);
      if (to_b) hq_b.push_back(e);
    end
  endtask

  // ---------------- monitors ----------------
  bit         mon_en = 0;
  logic [5:0] ph_a = '0, ph_b = '0, pg_a = '0, pg_b = '0;
  int         lc_a = 0, lc_b = 0, lg_a = 0, lg_b = 0;
  int         na = 0, nb = 0;
  int         ma_pos = 0, ma_spd = 1, ma_cnt = 0;
  int         mb_pos = 0, mb_spd = 1, mb_cnt = 0;
  bit         seen60 = 0;
  bit         pre60;
  hexp_t      e_a, e_b;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (mon_en) begin
      // heights
      if (ifa.dinosaur_height !== ph_a) begin
        if (hq_a.size() == 0) chk("a_height_unexpected", ifa.dinosaur_height, ph_a);
        else begin
          e_a = hq_a.pop_front();
          chk("a_height", ifa.dinosaur_height, e_a.h);
          if (!e_a.first) chk("a_height_step_cycles", cyc - lc_a, TA);
        end
        lc_a = cyc;
        ph_a = ifa.dinosaur_height;
      end
      if (ifb.dinosaur_height !== ph_b) begin
        if (hq_b.size() == 0) chk("b_height_unexpected", ifb.dinosaur_height, ph_b);
        else begin
          e_b = hq_b.pop_front();
          chk("b_height", ifb.dinosaur_height, e_b.h);
          if (!e_b.first) chk("b_height_step_cycles", cyc - lc_b, TB);
        end
        lc_b = cyc;
        ph_b = ifb.dinosaur_height;
      end
      // ground a
      if (ifa.ground_position !== pg_a) begin
        na++;
        ma_pos = (ma_pos + ma_spd) % 64;
        ma_cnt++;
        if (ma_cnt == STA) begin
          ma_cnt = 0;
          if (ma_spd < 15) ma_spd++;
        end
        chk("a_ground_pos", ifa.ground_position, ma_pos);
        chk("a_speed", ifa.speed, ma_spd);
        if (na > 1) chk("a_ground_step_cycles", cyc - lg_a, TA);
        if (na == 64) chk("a_wrap64", ifa.ground_position, 0);
        lg_a = cyc;
        pg_a = ifa.ground_position;
      end
      // ground b
      if (ifb.ground_position !== pg_b) begin
        nb++;
        pre60  = (mb_pos == 60) && (mb_spd == 15);
        mb_pos = (mb_pos + mb_spd) % 64;
        mb_cnt++;
        if (mb_cnt == STB) begin
          mb_cnt = 0;
          if (mb_spd < 15) mb_spd++;
        end
        chk("b_ground_pos", ifb.ground_position, mb_pos);
        chk("b_speed", ifb.speed, mb_spd);
        if (nb > 1) chk("b_ground_step_cycles", cyc - lg_b, TB);
        if (nb == 2) chk("b_speed_after_2_ticks", ifb.speed, 2);
        if (nb == 40) chk("b_speed_saturated", ifb.speed, SPEED_MAX);
        if (pre60) begin
          chk("b_wrap60_to_11", ifb.ground_position, 11);
          seen60 = 1;
        end
        lg_b = cyc;
        pg_b = ifb.ground_position;
      end
    end
  end

  // ---------------- debounce vectors ----------------
  typedef struct {
    logic [15:0] sw;
    int          hold;
    logic [15:0] exp_ok;
  } deb_vec_t;

  localparam int NV = 12;
  deb_vec_t vec [NV];

  initial begin
    int to;
    vec[0]  = '{16'h0008, 15, 16'h0000};  // SW3 settling, one short
    vec[1]  = '{16'h0008,  1, 16'h0008};  // 16th edge
    vec[2]  = '{16'h0028, 10, 16'h0008};  // 10-cycle pulse on SW5
    vec[3]  = '{16'h0008, 20, 16'h0008};  // pulse gone, SW5 never moved
    vec[4]  = '{16'hFFF0, 15, 16'h0008};
    vec[5]  = '{16'hFFF0,  1, 16'hFFF0};
    vec[6]  = '{16'h0F0F, 16, 16'h0F0F};
    vec[7]  = '{16'h0000, 16, 16'h0000};
    vec[8]  = '{16'h0001, 12, 16'h0000};
    vec[9]  = '{16'h0000,  1, 16'h0000};  // one-cycle dropout restarts count
    vec[10] = '{16'h0001, 15, 16'h0000};
    vec[11] = '{16'h0001,  1, 16'h0001};

    repeat (3) @(negedge CLK);
    check_reset("in_reset");
    clrn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      sw = vec[i].sw;
      repeat (vec[i].hold) @(negedge CLK);
      chk($sformatf("deb_vec%0d_a", i), ifa.SW_OK, vec[i].exp_ok);
      chk($sformatf("deb_vec%0d_b", i), ifb.SW_OK, vec[i].exp_ok);
    end

    // many ticks have passed while idle
    chk("idle_a_pos", ifa.ground_position, 0);
    chk("idle_b_pos", ifb.ground_position, 0);
    chk("idle_a_status", ifa.game_status, 0);
    chk("idle_a_height", ifa.dinosaur_height, 0);

    // start: the same press starts the game and the first jump
    mon_en = 1;
    push_jump(1, 1);
    btn = 1'b1;
    repeat (16) @(negedge CLK);
    chk("start_status_a_pre", ifa.game_status, 0);
    chk("start_status_b_pre", ifb.game_status, 0);
    @(negedge CLK);
    chk("start_status_a", ifa.game_status, 1);
    chk("start_status_b", ifb.game_status, 1);
    repeat (3) @(negedge CLK);
    btn = 1'b0;

    // mid-air press on b (dut_a is back on the ground and jumps again)
    to = 0;
    while (ifb.dinosaur_height != 3 && to < 300) begin
      @(negedge CLK);
      to++;
    end
    chk("b_reach_h3", ifb.dinosaur_height, 3);
    push_jump(1, 0);
    btn = 1'b1;
    repeat (20) @(negedge CLK);
    btn = 1'b0;
    chk("b_status_held", ifb.game_status, 1);

    // b lands, then a fresh press jumps both
    to = 0;
    while ((hq_b.size() != 0 || ifb.dinosaur_height != 0) && to < 600) begin
      @(negedge CLK);
      to++;
    end
    chk("b_landed_queue", hq_b.size(), 0);
    chk("a_landed_queue", hq_a.size(), 0);
    push_jump(1, 1);
    btn = 1'b1;
    repeat (20) @(negedge CLK);
    btn = 1'b0;
    to = 0;
    while ((hq_a.size() != 0 || hq_b.size() != 0) && to < 600) begin
      @(negedge CLK);
      to++;
    end
    chk("rejump_a_done", hq_a.size(), 0);
    chk("rejump_b_done", hq_b.size(), 0);

    // keep running until b has ramped, saturated and wrapped
    to = 0;
    while (nb < 100 && to < 4000) begin
      @(negedge CLK);
      to++;
    end
    chk("b_tick_count", nb >= 100, 1);
    chk("b_wrap60_seen", seen60, 1);
    chk("a_wrap64_seen", na >= 64, 1);
    chk("a_final_height", ifa.dinosaur_height, 0);
    mon_en = 0;

    // reset in the middle of a jump and of a switch debounce
    btn = 1'b1;
    to = 0;
    while (ifa.dinosaur_height != 2 && to < 300) begin
      @(negedge CLK);
      to++;
    end
    chk("a_reach_h2", ifa.dinosaur_height, 2);
    btn = 1'b0;
    sw  = 16'hFFFF;
    to = 0;
    while (ifa.dinosaur_height != 3 && to < 20) begin
      @(negedge CLK);
      to++;
    end
    chk("a_reach_h3", ifa.dinosaur_height, 3);
    #2 clrn = 1'b0;
    #1 check_reset("async");
    repeat (2) @(negedge CLK);
    clrn = 1'b1;
    @(negedge CLK);
    check_reset("post_release");
    repeat (14) @(negedge CLK);
    chk("post_rst_sw_15", ifa.SW_OK, 16'h0000);
    @(negedge CLK);
    chk("post_rst_sw_16", ifa.SW_OK, 16'hFFFF);
    chk("post_rst_status", ifa.game_status, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dino_motion_ctrl.md
# dino_motion_ctrl

Input conditioning and motion state for the dinosaur runner game. It debounces the 16 slide switches and the jump button. It runs the jump trajectory and the scrolling-ground position/speed, and holds the run/idle game status. Its outputs feed the renderer and VGA path in the top level.

## Interface
- `DEB_BITS`, default 4: debounce counter width; an input must hold a new value for 2^DEB_BITS consecutive cycles.
- `TICK_CYCLES`, default 1_000_000: CLK cycles per motion tick (minimum 2).
- `JUMP_PEAK`, default 40: apex height of a jump, range 1..63.
- `SPEED_TICKS`, default 256: motion ticks between speed increments.
- `CLK`  in  1  system clock; all state is on its rising edge.
- `clrn`  in  1  asynchronous, active-low reset.
- `BTN_JUMP`  in  1  raw jump button, active-high.
- `SW`  in  16  raw slide switches.
- `SW_OK`  out  16  debounced switches.
- `dinosaur_height`  out  6  current dinosaur height above the ground; 0 means on the ground.
- `game_status`  out  1  0 = idle, 1 = running.
- `speed`  out  4  ground scroll speed, 1..15.
- `ground_position`  out  6  ground scroll offset, modulo 64.

## Operation
**Debounce**
- One debouncer per bit: 16 switch bits plus BTN_JUMP.
- Per bit: output O, counter C of DEB_BITS bits.
- If I == O, C is cleared to 0.
- If I != O and C < 2^DEB_BITS-1, C increments.
- If I != O and C == 2^DEB_BITS-1, O is set to I and C is cleared to 0.

**Tick**
- Free-running counter over 0..TICK_CYCLES-1.
- A one-cycle `tick` pulse is generated when the counter wraps to 0.
- The counter runs in both idle and running states.

**Press detect**
- `press` = debounced button rising edge: current debounced value is 1 and the previous-cycle registered value is 0.

**Game status**
- Idle → running on `press`.
- Running is left only by reset.

**Jump state machine**
- States: GROUND, RISE, FALL.
- GROUND → RISE on `press` while game_status == 1, or on the same `press` that starts the game. Height is unchanged on this edge.
- RISE: on each tick, height increments by 1. When height reaches JUMP_PEAK, the state becomes FALL on the same edge.
- FALL: on each tick, height decrements by 1. When height reaches 0, the state becomes GROUND on the same edge.
- `press` in RISE or FALL is ignored; there is no double jump.
- Height never exceeds JUMP_PEAK and never wraps below 0.

**Ground**
- Updates only on tick while game_status == 1.
- ground_position ← (ground_position + speed) mod 64, 6-bit wrap.
- A tick counter counts ticks. When it reaches SPEED_TICKS, it clears and speed increments, saturating at 15.
- When speed and position change on the same tick, the position uses the old speed.

## Timing
**Reset values** (asynchronous on clrn = 0; each value holds until the first CLK edge after release)
- SW_OK = 0, debounce counters = 0, debounced button = 0.
- dinosaur_height = 0, jump state = GROUND, game_status = 0.
- speed = 1, ground_position = 0, tick counter = 0, speed counter = 0.

**Latency**
- Debounce: O changes on the 2^DEB_BITS-th consecutive edge with I != O. At the default, this is 16 cycles after the input settles.
- A glitch shorter than that leaves O unchanged and restarts counting.
- `press` is asserted on the cycle after the debounced button rises.
- game_status and the RISE state are registered one edge after `press`.
- A jump of JUMP_PEAK = 40 lasts 80 ticks from the first rise to landing.

**Reset mid-operation**
- Reset mid-jump or mid-debounce aborts everything to the reset values.
- Outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `dino_pkg`: default parameter constants, jump-state enum (GROUND, RISE, FALL), and `SPEED_MAX = 4'd15`.
- One natural sub-module: `anti_jitter`, a single-bit debouncer parameterised by DEB_BITS.
- `anti_jitter` is instantiated 17 times.
- The top contains the tick generator, press detect, jump FSM and ground logic.

## Test plan
1. **Switch debounce:** DEB_BITS = 4; SW[3] goes 0→1 and holds. SW_OK[3] must be 0 through cycle 15 and 1 at cycle 16. A 10-cycle pulse on SW[5] leaves SW_OK[5] at 0.
2. **Start:** press BTN_JUMP for 20 cycles. One cycle after `press`, game_status = 1. With TICK_CYCLES = 4 and JUMP_PEAK = 5, height must step 1,2,3,4,5,4,3,2,1,0, one step per tick, then stay 0.
3. **No double jump:** a second press while height is 3 in RISE leaves the trajectory unchanged. A press after landing starts a new jump.
4. **Ground wrap:** running, speed = 1. After 64 ticks, ground_position = 0. Before the game starts, ground_position stays 0 regardless of ticks.
5. **Speed ramp:** SPEED_TICKS = 2. Speed must read 2 after 2 ticks and saturate at 15. At speed 15, position 60 → 11 on the next tick.
6. **Reset:** assert clrn = 0 mid-jump at height 3. All outputs must return to reset values immediately, asynchronously.
